pipeline_stall_controller: RTL and testbench
============================================

Name: pipeline_stall_controller

Overview:
- Central hazard and stall sequencer for the 5-stage pipeline.
- Drives the enable and flush inputs of the pipeline registers (fetch/decode, decode/execute, execute/memory) and the PC register.
- Resolves load-use hazards, taken-branch redirects, and multi-cycle mult/div occupancy of the execute stage.
- Sits beside the datapath; the datapath only supplies hazard indications to it.

Parameters:
- REGBITS, 5, width of register specifiers.
- MD_TIMEOUT, 40, maximum cycles to wait for mult/div completion before abort.
- CNTBITS, 32, width of the stall performance counter.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- dx_is_load  in  1  instruction in execute is a load
- dx_rd  in  REGBITS  destination register of the execute-stage instruction
- fd_rs1  in  REGBITS  source 1 of the decode-stage instruction
- fd_rs2  in  REGBITS  source 2 of the decode-stage instruction
- fd_uses_rs2  in  1  decode-stage instruction reads rs2
- branch_taken  in  1  execute resolved a taken branch or jump this cycle
- md_start  in  1  mult/div operation entering execute this cycle
- md_ready  in  1  mult/div result valid
- pc_enable  out  1  PC register write enable
- fd_enable  out  1  fetch/decode register enable
- fd_flush  out  1  fetch/decode register synchronous clear (bubble)
- dx_flush  out  1  decode/execute register clear (bubble)
- xm_enable  out  1  execute/memory register enable
- md_busy  out  1  controller is in MD_WAIT
- md_timeout  out  1  one-cycle pulse on mult/div abort
- stall_count  out  CNTBITS  cycles in which pc_enable was 0, saturating

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - reset is asynchronous and active-high: state=IDLE, counters=0, md_timeout=0.
  - While reset is high, all enables and flushes are 0.
- Outputs are combinational from state plus inputs, so control takes effect in the same cycle (zero latency).
- Load-use hazard (lu) = dx_is_load & (dx_rd!=0) & (dx_rd==fd_rs1 | (fd_uses_rs2 & dx_rd==fd_rs2)).
- IDLE, priority order:
  1. branch_taken: pc_enable=1, fd_enable=1, fd_flush=1, dx_flush=1, xm_enable=1. Load-use is ignored because the dependent instruction is squashed.
  2. md_start: xm_enable=0, pc_enable=0, fd_enable=0, dx_flush=0. Load wait counter with 0. Next state MD_WAIT.
  3. lu: pc_enable=0, fd_enable=0, dx_flush=1, xm_enable=1. This inserts exactly one bubble; the next cycle re-evaluates.
  4. Otherwise: all enables 1, all flushes 0.
- MD_WAIT:
  - pc_enable=fd_enable=xm_enable=0, flushes 0, md_busy=1.
  - branch_taken, md_start and lu are ignored; execute is frozen.
  - md_ready=1: next state MD_DONE.
  - Else, when wait counter == MD_TIMEOUT-1: next state IDLE, md_timeout=1 for one cycle, dx_flush=1 that cycle (abort drops the op).
  - Else: wait counter increments.
- MD_DONE:
  - Exactly one cycle; all enables 1, flushes 0; result advances to memory.
  - Next state IDLE.
  - Same-cycle md_start is ignored; a back-to-back mult/div is accepted on the following IDLE cycle.
- md_ready while in IDLE or MD_DONE: ignored.
- stall_count: increments each cycle pc_enable=0 and reset is low; saturates at all ones and does not wrap.
- Reset mid-MD_WAIT returns to IDLE immediately; no md_timeout pulse.
- State encoding: 2 bits; the unused code behaves as IDLE.

Decomposition:
- Shared package pipeline_ctrl_pkg holds the state encodings (IDLE, MD_WAIT, MD_DONE) and the default MD_TIMEOUT constant.
- One natural sub-module: load_use_detect, combinational, computing lu from the dx and fd register fields. It is reusable by the forwarding unit.

Test Plan:
- Load-use: dx_is_load=1, dx_rd=5, fd_rs1=5 for one cycle -> pc_enable=0, fd_enable=0, dx_flush=1 that cycle; normal operation next cycle; stall_count=1.
- Zero register: dx_is_load=1, dx_rd=0, fd_rs1=0 -> no stall, all enables 1.
- Branch beats load-use: branch_taken=1 with lu true -> fd_flush=1, dx_flush=1, pc_enable=1, stall_count unchanged.
- Mult/div: md_start at cycle 0, md_ready at cycle 5 -> md_busy=1 for cycles 1-5, MD_DONE at cycle 6 with xm_enable=1, IDLE at cycle 7; stall_count=6.
- Timeout: md_start with md_ready held 0 -> md_timeout pulses exactly MD_TIMEOUT cycles after entering MD_WAIT, dx_flush=1 that cycle, returns to IDLE.
- Reset: assert reset in MD_WAIT cycle 3 -> state IDLE asynchronously, all outputs 0, stall_count=0, no md_timeout; saturation check with CNTBITS=4 holds at 15.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline stall controller and its helpers.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        MD_WAIT = 2'b01,
        MD_DONE = 2'b10
    } state_t;

    localparam int DEFAULT_MD_TIMEOUT = 40;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detector: the decode-stage instruction needs a value that
// the execute-stage load has not produced yet.
module load_use_detect #(
    parameter int REGBITS = 5
) (
    input  logic               dx_is_load,
    input  logic [REGBITS-1:0] dx_rd,
    input  logic [REGBITS-1:0] fd_rs1,
    input  logic [REGBITS-1:0] fd_rs2,
    input  logic               fd_uses_rs2,
    output logic               lu
);

    // Register 0 is hardwired to zero, so a load targeting it never creates a dependency.
    assign lu = dx_is_load && (dx_rd != '0) &&
                ((dx_rd == fd_rs1) || (fd_uses_rs2 && (dx_rd == fd_rs2)));

endmodule

// File: rtl/pipeline_stall_controller.sv
// Hazard and stall sequencer for the 5-stage pipeline: drives PC and pipeline
// register enables/flushes for load-use, branch redirect and mult/div occupancy.
module pipeline_stall_controller
    import pipeline_ctrl_pkg::*;
#(
    parameter int REGBITS    = 5,
    parameter int MD_TIMEOUT = DEFAULT_MD_TIMEOUT,
    parameter int CNTBITS    = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               dx_is_load,
    input  logic [REGBITS-1:0] dx_rd,
    input  logic [REGBITS-1:0] fd_rs1,
    input  logic [REGBITS-1:0] fd_rs2,
    input  logic               fd_uses_rs2,
    input  logic               branch_taken,
    input  logic               md_start,
    input  logic               md_ready,
    output logic               pc_enable,
    output logic               fd_enable,
    output logic               fd_flush,
    output logic               dx_flush,
    output logic               xm_enable,
    output logic               md_busy,
    output logic               md_timeout,
    output logic [CNTBITS-1:0] stall_count
);

    localparam int                  WAITBITS  = $clog2(MD_TIMEOUT + 1);
    localparam logic [WAITBITS-1:0] WAIT_LAST = WAITBITS'(MD_TIMEOUT - 1);

    state_t              state;
    state_t              state_next;
    logic [WAITBITS-1:0] wait_count;
    logic [WAITBITS-1:0] wait_count_next;
    logic                lu;

    load_use_detect #(
        .REGBITS(REGBITS)
    ) u_load_use_detect (
        .dx_is_load (dx_is_load),
        .dx_rd      (dx_rd),
        .fd_rs1     (fd_rs1),
        .fd_rs2     (fd_rs2),
        .fd_uses_rs2(fd_uses_rs2),
        .lu         (lu)
    );

    // NOTE: every output and next-state value gets a default before the case,
    // so no path through this block leaves a signal unassigned (no latches).
    always_comb begin
        state_next      = state;
        wait_count_next = wait_count;
        pc_enable       = 1'b1;
        fd_enable       = 1'b1;
        fd_flush        = 1'b0;
        dx_flush        = 1'b0;
        xm_enable       = 1'b1;
        md_busy         = 1'b0;
        md_timeout      = 1'b0;

        case (state)
            MD_WAIT: begin
                pc_enable = 1'b0;
                fd_enable = 1'b0;
                xm_enable = 1'b0;
                md_busy   = 1'b1;
                if (md_ready) begin
                    state_next = MD_DONE;
                end else if (wait_count == WAIT_LAST) begin
                    // Abort: the stuck op is dropped by bubbling decode/execute.
                    state_next = IDLE;
                    md_timeout = 1'b1;
                    dx_flush   = 1'b1;
                end else begin
                    wait_count_next = wait_count + WAITBITS'(1);
                end
            end

            MD_DONE: begin
                state_next = IDLE;
            end

            default: begin
                // IDLE, and the unused encoding which recovers to IDLE.
                state_next = IDLE;
                if (branch_taken) begin
                    fd_flush = 1'b1;
                    dx_flush = 1'b1;
                end else if (md_start) begin
                    pc_enable       = 1'b0;
                    fd_enable       = 1'b0;
                    xm_enable       = 1'b0;
                    wait_count_next = '0;
                    state_next      = MD_WAIT;
                end else if (lu) begin
                    pc_enable = 1'b0;
                    fd_enable = 1'b0;
                    dx_flush  = 1'b1;
                end
            end
        endcase

        if (reset) begin
            pc_enable  = 1'b0;
            fd_enable  = 1'b0;
            fd_flush   = 1'b0;
            dx_flush   = 1'b0;
            xm_enable  = 1'b0;
            md_busy    = 1'b0;
            md_timeout = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            wait_count <= '0;
        end else begin
            state      <= state_next;
            wait_count <= wait_count_next;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_count <= '0;
        end else if (!pc_enable && (stall_count != '1)) begin
            stall_count <= stall_count + CNTBITS'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed self-checking bench for pipeline_stall_controller; a second instance
// with a 4-bit counter covers stall_count saturation.
module tb_pipeline_stall_controller;

    logic       clock = 1'b0;
    logic       reset;
    logic       dx_is_load;
    logic [4:0] dx_rd;
    logic [4:0] fd_rs1;
    logic [4:0] fd_rs2;
    logic       fd_uses_rs2;
    logic       branch_taken;
    logic       md_start;
    logic       md_ready;

    logic        pc_enable, fd_enable, fd_flush, dx_flush, xm_enable, md_busy, md_timeout;
    logic [31:0] stall_count;
    logic        s_pc_enable, s_fd_enable, s_fd_flush, s_dx_flush, s_xm_enable, s_md_busy, s_md_timeout;
    logic [3:0]  sat_count;
    logic [6:0]  ctl;

    int n_checks = 0;
    int n_fail   = 0;

    // Control vector order: pc_enable, fd_enable, fd_flush, dx_flush, xm_enable, md_busy, md_timeout
    localparam logic [6:0] C_RUN    = 7'b1100100;
    localparam logic [6:0] C_LU     = 7'b0001100;
    localparam logic [6:0] C_BRANCH = 7'b1111100;
    localparam logic [6:0] C_ZERO   = 7'b0000000;
    localparam logic [6:0] C_WAIT   = 7'b0000010;
    localparam logic [6:0] C_ABORT  = 7'b0001011;

    assign ctl = {pc_enable, fd_enable, fd_flush, dx_flush, xm_enable, md_busy, md_timeout};

    always #5 clock = ~clock;

    pipeline_stall_controller #(
        .REGBITS(5), .MD_TIMEOUT(40), .CNTBITS(32)
    ) dut (
        .clock(clock), .reset(reset), .dx_is_load(dx_is_load), .dx_rd(dx_rd),
        .fd_rs1(fd_rs1), .fd_rs2(fd_rs2), .fd_uses_rs2(fd_uses_rs2),
        .branch_taken(branch_taken), .md_start(md_start), .md_ready(md_ready),
        .pc_enable(pc_enable), .fd_enable(fd_enable), .fd_flush(fd_flush),
        .dx_flush(dx_flush), .xm_enable(xm_enable), .md_busy(md_busy),
        .md_timeout(md_timeout), .stall_count(stall_count)
    );

    pipeline_stall_controller #(
        .REGBITS(5), .MD_TIMEOUT(40), .CNTBITS(4)
    ) sat_dut (
        .clock(clock), .reset(reset), .dx_is_load(dx_is_load), .dx_rd(dx_rd),
        .fd_rs1(fd_rs1), .fd_rs2(fd_rs2), .fd_uses_rs2(fd_uses_rs2),
        .branch_taken(branch_taken), .md_start(md_start), .md_ready(md_ready),
        .pc_enable(s_pc_enable), .fd_enable(s_fd_enable), .fd_flush(s_fd_flush),
        .dx_flush(s_dx_flush), .xm_enable(s_xm_enable), .md_busy(s_md_busy),
        .md_timeout(s_md_timeout), .stall_count(sat_count)
    );

    // Inputs change at posedge+1; checks happen at posedge+2.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic quiet_inputs();
        dx_is_load   = 1'b0;
        dx_rd        = 5'd0;
        fd_rs1       = 5'd0;
        fd_rs2       = 5'd0;
        fd_uses_rs2  = 1'b0;
        branch_taken = 1'b0;
        md_start     = 1'b0;
        md_ready     = 1'b0;
    endtask

    task automatic do_reset();
        quiet_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        quiet_inputs();
        reset = 1'b1;
        #1;
        n_checks++;
        if (ctl !== C_ZERO) begin
            n_fail++; $display("FAIL reset_ctl: got %b expected %b", ctl, C_ZERO);
        end
        n_checks++;
        if (stall_count !== 32'd0) begin
            n_fail++; $display("FAIL reset_count: got %0d expected 0", stall_count);
        end
        tick();
        reset = 1'b0;
        #1;
        n_checks++;
        if (ctl !== C_RUN) begin
            n_fail++; $display("FAIL post_reset_ctl: got %b expected %b", ctl, C_RUN);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        dx_is_load = 1'b1; dx_rd = 5'd5; fd_rs1 = 5'd5; fd_rs2 = 5'd7;
        #1;
        n_checks++;
        if (ctl !== C_LU) begin
            n_fail++; $display("FAIL lu_rs1_ctl: got %b expected %b", ctl, C_LU);
        end
        tick();
        quiet_inputs();
        #1;
        n_checks++;
        if (ctl !== C_RUN) begin
            n_fail++; $display("FAIL lu_next_ctl: got %b expected %b", ctl, C_RUN);
        end
        n_checks++;
        if (stall_count !== 32'd1) begin
            n_fail++; $display("FAIL lu_count: got %0d expected 1", stall_count);
        end
        tick();
        dx_is_load = 1'b1; dx_rd = 5'd9; fd_rs1 = 5'd3; fd_rs2 = 5'd9; fd_uses_rs2 = 1'b1;
        #1;
        n_checks++;
        if (ctl !== C_LU) begin
            n_fail++; $display("FAIL lu_rs2_ctl: got %b expected %b", ctl, C_LU);
        end
        tick();
        fd_uses_rs2 = 1'b0;
        #1;
        n_checks++;
        if (ctl !== C_RUN) begin
            n_fail++; $display("FAIL lu_rs2_unused_ctl: got %b expected %b", ctl, C_RUN);
        end
        tick();
        dx_is_load = 1'b0; fd_rs1 = 5'd9;
        #1;
        n_checks++;
        if (ctl !== C_RUN) begin
            n_fail++; $display("FAIL lu_not_load_ctl: got %b expected %b", ctl, C_RUN);
        end
        tick();
        quiet_inputs();
        #1;
        n_checks++;
        if (stall_count !== 32'd2) begin
            n_fail++; $display("FAIL lu_total_count: got %0d expected 2", stall_count);
        end
    endtask

    task automatic test_zero_reg();
        do_reset();
        dx_is_load = 1'b1; dx_rd = 5'd0; fd_rs1 = 5'd0; fd_rs2 = 5'd0; fd_uses_rs2 = 1'b1;
        #1;
        n_checks++;
        if (ctl !== C_RUN) begin
            n_fail++; $display("FAIL zero_reg_ctl: got %b expected %b", ctl, C_RUN);
        end
        tick();
        quiet_inputs();
        #1;
        n_checks++;
        if (stall_count !== 32'd0) begin
            n_fail++; $display("FAIL zero_reg_count: got %0d expected 0", stall_count);
        end
    endtask

    task automatic test_branch();
        do_reset();
        branch_taken = 1'b1; dx_is_load = 1'b1; dx_rd = 5'd5; fd_rs1 = 5'd5;
        #1;
        n_checks++;
        if (ctl !== C_BRANCH) begin
            n_fail++; $display("FAIL branch_lu_ctl: got %b expected %b", ctl, C_BRANCH);
        end
        tick();
        dx_is_load = 1'b0; md_start = 1'b1;
        #1;
        n_checks++;
        if (ctl !== C_BRANCH) begin
            n_fail++; $display("FAIL branch_md_ctl: got %b expected %b", ctl, C_BRANCH);
        end
        tick();
        quiet_inputs();
        #1;
        n_checks++;
        if (ctl !== C_RUN) begin
            n_fail++; $display("FAIL branch_after_ctl: got %b expected %b", ctl, C_RUN);
        end
        n_checks++;
        if (stall_count !== 32'd0) begin
            n_fail++; $display("FAIL branch_count: got %0d expected 0", stall_count);
        end
    endtask

    task automatic test_mult_div();
        logic [6:0] exp_ctl;
        do_reset();
        // cycle 0: md_start wins over a simultaneous load-use
        md_start = 1'b1; dx_is_load = 1'b1; dx_rd = 5'd5; fd_rs1 = 5'd5;
        #1;
        n_checks++;
        if (ctl !== C_ZERO) begin
            n_fail++; $display("FAIL md_start_ctl: got %b expected %b", ctl, C_ZERO);
        end
        tick();
        quiet_inputs();
        for (int c = 1; c <= 5; c++) begin
            branch_taken = (c == 2);
            md_start     = (c == 3);
            md_ready     = (c == 5);
            #1;
            n_checks++;
            if (ctl !== C_WAIT) begin
                n_fail++; $display("FAIL md_wait_ctl cycle %0d: got %b expected %b", c, ctl, C_WAIT);
            end
            tick();
        end
        // cycle 6: MD_DONE, same-cycle md_start ignored
        quiet_inputs();
        md_start = 1'b1;
        #1;
        n_checks++;
        if (ctl !== C_RUN) begin
            n_fail++; $display("FAIL md_done_ctl: got %b expected %b", ctl, C_RUN);
        end
        tick();
        // cycle 7: back-to-back op accepted in IDLE
        #1;
        n_checks++;
        if (stall_count !== 32'd6) begin
            n_fail++; $display("FAIL md_count: got %0d expected 6", stall_count);
        end
        n_checks++;
        if (ctl !== C_ZERO) begin
            n_fail++; $display("FAIL md_b2b_start_ctl: got %b expected %b", ctl, C_ZERO);
        end
        tick();
        md_start = 1'b0; md_ready = 1'b1;
        #1;
        n_checks++;
        if (ctl !== C_WAIT) begin
            n_fail++; $display("FAIL md_b2b_wait_ctl: got %b expected %b", ctl, C_WAIT);
        end
        tick();
        md_ready = 1'b0;
        #1;
        n_checks++;
        if (ctl !== C_RUN) begin
            n_fail++; $display("FAIL md_b2b_done_ctl: got %b expected %b", ctl, C_RUN);
        end
        tick();
        // md_ready in IDLE must not start anything
        md_ready = 1'b1;
        #1;
        n_checks++;
        if (ctl !== C_RUN) begin
            n_fail++; $display("FAIL md_ready_idle_ctl: got %b expected %b", ctl, C_RUN);
        end
        tick();
        md_ready = 1'b0;
        #1;
        exp_ctl = C_RUN;
        n_checks++;
        if (ctl !== exp_ctl) begin
            n_fail++; $display("FAIL md_ready_idle_next_ctl: got %b expected %b", ctl, exp_ctl);
        end
        n_checks++;
        if (stall_count !== 32'd8) begin
            n_fail++; $display("FAIL md_b2b_count: got %0d expected 8", stall_count);
        end
    endtask

    task automatic test_timeout();
        logic [6:0] exp_ctl;
        do_reset();
        md_start = 1'b1;
        #1;
        n_checks++;
        if (ctl !== C_ZERO) begin
            n_fail++; $display("FAIL to_start_ctl: got %b expected %b", ctl, C_ZERO);
        end
        tick();
        md_start = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            #1;
            exp_ctl = (k == 40) ? C_ABORT : C_WAIT;
            n_checks++;
            if (ctl !== exp_ctl) begin
                n_fail++; $display("FAIL to_wait_ctl cycle %0d: got %b expected %b", k, ctl, exp_ctl);
            end
            if (k == 14) begin
                n_checks++;
                if (sat_count !== 4'd14) begin
                    n_fail++; $display("FAIL sat_mid_count: got %0d expected 14", sat_count);
                end
            end
            tick();
        end
        #1;
        n_checks++;
        if (ctl !== C_RUN) begin
            n_fail++; $display("FAIL to_idle_ctl: got %b expected %b", ctl, C_RUN);
        end
        n_checks++;
        if (stall_count !== 32'd41) begin
            n_fail++; $display("FAIL to_count: got %0d expected 41", stall_count);
        end
        n_checks++;
        if (sat_count !== 4'd15) begin
            n_fail++; $display("FAIL sat_hold_count: got %0d expected 15", sat_count);
        end
    endtask

    task automatic test_reset_mid_wait();
        logic seen_timeout;
        do_reset();
        md_start = 1'b1;
        tick();
        md_start = 1'b0;
        tick();
        tick();
        // cycle 3 in MD_WAIT
        #1;
        n_checks++;
        if (ctl !== C_WAIT) begin
            n_fail++; $display("FAIL rst_mid_pre_ctl: got %b expected %b", ctl, C_WAIT);
        end
        #1;
        reset = 1'b1;
        #1;
        n_checks++;
        if (ctl !== C_ZERO) begin
            n_fail++; $display("FAIL rst_mid_ctl: got %b expected %b", ctl, C_ZERO);
        end
        n_checks++;
        if (stall_count !== 32'd0) begin
            n_fail++; $display("FAIL rst_mid_count: got %0d expected 0", stall_count);
        end
        tick();
        reset = 1'b0;
        #1;
        n_checks++;
        if (ctl !== C_RUN) begin
            n_fail++; $display("FAIL rst_mid_release_ctl: got %b expected %b", ctl, C_RUN);
        end
        seen_timeout = 1'b0;
        for (int k = 0; k < 45; k++) begin
            tick();
            #1;
            if (md_timeout !== 1'b0 || md_busy !== 1'b0) seen_timeout = 1'b1;
        end
        n_checks++;
        if (seen_timeout !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_no_timeout: got %b expected 0", seen_timeout);
        end
        n_checks++;
        if (stall_count !== 32'd0) begin
            n_fail++; $display("FAIL rst_mid_final_count: got %0d expected 0", stall_count);
        end
    endtask

    initial begin
        quiet_inputs();
        reset = 1'b1;
        test_reset();
        test_load_use();
        test_zero_reg();
        test_branch();
        test_mult_div();
        test_timeout();
        test_reset_mid_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
